fpu_mul_iter: RTL and testbench

FPU_MUL_ITER -- requirements
Module: fpu_mul_iter

---
 rtl/fpu_mul_iter.sv | 161 ++++++++++++++++
 tb/tb_fpu_mul_iter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_iter.sv
// Iterative IEEE-754 multiplier: one significand bit per cycle (radix-2 shift-add),
// round-to-nearest-even, saturate to infinity on overflow, flush to zero on underflow.
`timescale 1ns/1ps
module fpu_mul_iter #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int WIDTH = 1 + EXP_W + MAN_W,
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int XW     = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W + 1);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_BIAS = XW'(BIAS);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t state, state_nx;

  // Operand field decode (only consumed on the accept edge)
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  logic a_zero, b_zero, a_max, b_max, a_inf, b_inf, a_nan, b_nan, special, accept;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_max   = (ea == '1);
  assign b_max   = (eb == '1);
  assign a_inf   = a_max && (ma == '0);
  assign b_inf   = b_max && (mb == '0);
  assign a_nan   = a_max && (ma != '0);
  assign b_nan   = b_max && (mb != '0);
  assign special = a_zero | b_zero | a_max | b_max;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  logic [WIDTH-1:0] special_res;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    special_res = {sa ^ sb, {(EXP_W + MAN_W){1'b0}}};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      special_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
    else if (a_inf || b_inf)
      special_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic signed [XW-1:0] exp_in;
  assign exp_in = XW'(ea) + XW'(eb) - EXP_BIAS;

  // Datapath registers
  logic                 sign_r;
  logic signed [XW-1:0] exp_r;
  logic [PROD_W-1:0]    acc, mcand;
  logic [SIG_W-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : MUL;
      MUL:     if (cnt == CNT_W'(1)) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the shift-add registers are deliberately left out of reset; they are always
  // reloaded on accept and never observed unless the control path says so.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r <= sa ^ sb;
      exp_r  <= exp_in;
      acc    <= '0;
      mcand  <= {{SIG_W{1'b0}}, 1'b1, mb};
      mplier <= {1'b1, ma};
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt <= '0;
    else if (accept && !special) cnt <= CNT_W'(SIG_W);
    else if (state == MUL)       cnt <= cnt - CNT_W'(1);
  end

  // Normalise, round and range-check the finished product
  logic [PROD_W-1:0]    norm_p;
  logic [MAN_W-1:0]     mant, mant_fin;
  logic                 guard, sticky, rnd;
  logic [SIG_W:0]       rsum;
  logic signed [XW-1:0] exp_fin;
  logic [WIDTH-1:0]     norm_res;
  logic                 norm_ovf, norm_unf;

  always_comb begin
    norm_p   = acc[PROD_W-1] ? acc : (acc << 1);
    mant     = norm_p[PROD_W-2 -: MAN_W];
    guard    = norm_p[MAN_W];
    sticky   = |norm_p[MAN_W-1:0];
    rnd      = guard & (sticky | mant[0]);
    rsum     = {1'b0, 1'b1, mant} + (SIG_W + 1)'(rnd);
    // A rounding carry out of the hidden bit means the significand became exactly 2.0
    mant_fin = rsum[SIG_W] ? '0 : rsum[MAN_W-1:0];
    exp_fin  = exp_r + XW'(acc[PROD_W-1]) + XW'(rsum[SIG_W]);
    norm_res = {sign_r, exp_fin[EXP_W-1:0], mant_fin};
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (exp_fin >= EXP_MAX) begin
      norm_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_ovf = 1'b1;
    end else if (exp_fin <= 0) begin
      norm_res = {sign_r, {(EXP_W + MAN_W){1'b0}}};
      norm_unf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (accept && special) begin
      result    <= special_res;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (state == NORM) begin
      result    <= norm_res;
      overflow  <= norm_ovf;
      underflow <= norm_unf;
    end
  end

endmodule

// File: tb/tb_fpu_mul_iter.sv
// Bench for fpu_mul_iter: directed vector table, randomized operands against an
// arithmetic RNE reference, handshake/reset sequences and a double-precision instance.
`timescale 1ns/1ps
module tb_fpu_mul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, overflow, underflow;
  logic [31:0] a, b, result;
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_overflow, d_underflow;
  logic [63:0] d_a, d_b, d_result;

  int checks   = 0;
  int failures = 0;

  fpu_mul_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow)
  );

  fpu_mul_iter #(.EXP_W(11), .MAN_W(52)) dut_dp (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result),
    .overflow(d_overflow), .underflow(d_underflow)
  );

  typedef struct {
    string       name;
    logic [31:0] a, b, r;
    logic        o, u;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] r, input logic o, input logic u, input int lat);
    vec_t v;
    v.name = n; v.a = x; v.b = y; v.r = r; v.o = o; v.u = u; v.lat = lat;
    return v;
  endfunction

  // Reference: exact integer product of the significands, rounded to 24 bits by division
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic o, output logic u);
    int ex, ey, e, k;
    logic s, x_nan, y_nan, x_inf, y_inf;
    longint unsigned p, q, unit, rem;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    x_nan = (ex == 255) && (x[22:0] != 0);
    y_nan = (ey == 255) && (y[22:0] != 0);
    x_inf = (ex == 255) && (x[22:0] == 0);
    y_inf = (ey == 255) && (y[22:0] == 0);
    o = 1'b0;
    u = 1'b0;
    if (x_nan || y_nan || (x_inf && ey == 0) || (y_inf && ex == 0)) r = 32'h7FC00000;
    else if (x_inf || y_inf) r = {s, 8'hFF, 23'h0};
    else if (ex == 0 || ey == 0) r = {s, 31'h0};
    else begin
      p = (64'(x[22:0]) + 64'h800000) * (64'(y[22:0]) + 64'h800000);
      e = ex + ey - 127;
      k = 23;
      if (p >= (64'd1 << 47)) begin
        k = 24;
        e++;
      end
      unit = 64'd1 << k;
      q    = p / unit;
      rem  = p % unit;
      if (rem > unit / 2 || (rem == unit / 2 && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        o = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        u = 1'b1;
      end else r = {s, 8'(e), 23'(q)};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        v[30:23] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        if ($urandom_range(0, 1)) v[22:0] = '0;
      end
      1, 2, 3: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Issue one operation, count edges from accept (inclusive) to out_valid, then consume it
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r,
                        output logic o, output logic u, output int lat);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
    end while (!out_valid && lat < 200);
    if (!out_valid) lat = -1;
    r = result;
    o = overflow;
    u = underflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] r, er, x, y;
  logic        o, u, eo, eu, seen;
  int          lat, n;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", {overflow, underflow}, 0);
    check("reset dp in_ready", d_in_ready, 1);
    check("reset dp result", d_result, 0);

    vecs.push_back(mk("neg6.4*neg0.5", 32'hC0CCCCCD, 32'hBF000000, 32'h404CCCCD, 0, 0, 26));
    vecs.push_back(mk("6.4*neg0.5",    32'h40CCCCCD, 32'hBF000000, 32'hC04CCCCD, 0, 0, 26));
    vecs.push_back(mk("3e25*1e14",     32'h69C68568, 32'h56B5E670, 32'h7F800000, 1, 0, 26));
    vecs.push_back(mk("3e-35*1e-14",   32'h061F86D0, 32'h28342600, 32'h00000000, 0, 1, 26));
    vecs.push_back(mk("qnan*1",        32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1));
    vecs.push_back(mk("inf*0",         32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1));
    vecs.push_back(mk("neginf*2",      32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 1));
    vecs.push_back(mk("0*neg2",        32'h00000000, 32'hC0000000, 32'h80000000, 0, 0, 1));
    vecs.push_back(mk("1*1",           32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 26));
    vecs.push_back(mk("2*3",           32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 26));
    vecs.push_back(mk("maxexp ovf",    32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0, 26));
    vecs.push_back(mk("minnorm unf",   32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 26));
    vecs.push_back(mk("tie odd up",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0, 0, 26));
    vecs.push_back(mk("tie even keep", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 0, 0, 26));

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, r, o, u, lat);
      check({vecs[i].name, " result"}, r, vecs[i].r);
      check({vecs[i].name, " flags"}, {o, u}, {vecs[i].o, vecs[i].u});
      check({vecs[i].name, " latency"}, lat, vecs[i].lat);
    end

    // 4.2*3.2 and 1.0132*-1235.3412 against the reference
    run_op(32'h40866666, 32'h404CCCCD, r, o, u, lat);
    ref_mul(32'h40866666, 32'h404CCCCD, er, eo, eu);
    check("4.2*3.2 result", r, er);
    run_op(32'h3F81B08A, 32'hC49A6AEB, r, o, u, lat);
    ref_mul(32'h3F81B08A, 32'hC49A6AEB, er, eo, eu);
    check("1.0132*neg1235.3412 result", r, er);

    for (int i = 0; i < 2000; i++) begin
      x = rand_fp();
      y = rand_fp();
      ref_mul(x, y, er, eo, eu);
      run_op(x, y, r, o, u, lat);
      check($sformatf("rand %h*%h result", x, y), r, er);
      check($sformatf("rand %h*%h flags", x, y), {o, u}, {eo, eu});
      check($sformatf("rand %h*%h latency", x, y), lat,
            (x[30:23] == 0 || x[30:23] == 8'hFF || y[30:23] == 0 || y[30:23] == 8'hFF) ? 1 : 26);
    end

    // Hold the result in DONE with out_ready low; new operands must be refused
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold reached done", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(negedge clk);
      check("hold result", result, 32'h40C00000);
      check("hold in_ready", in_ready, 0);
      check("hold out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release in_ready", in_ready, 1);
    check("release out_valid", out_valid, 0);
    check("release result held", result, 32'h40C00000);

    // Reset at MUL cycle 10 aborts the operation with no output
    @(negedge clk);
    a = 32'h40866666; b = 32'h404CCCCD; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-mul in_ready", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-mul rst in_ready", in_ready, 1);
    check("mid-mul rst out_valid", out_valid, 0);
    check("mid-mul rst result", result, 0);
    check("mid-mul rst flags", {overflow, underflow}, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid-mul rst no output", seen, 0);
    run_op(32'h40000000, 32'h40400000, r, o, u, lat);
    check("post-rst result", r, 32'h40C00000);
    check("post-rst latency", lat, 26);

    // Double precision: 1.5 * 2.0
    @(negedge clk);
    d_a = 64'h3FF8000000000000; d_b = 64'h4000000000000000; d_in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      d_in_valid = 1'b0;
    end while (!d_out_valid && lat < 200);
    check("dp result", d_result, 64'h4008000000000000);
    check("dp flags", {d_overflow, d_underflow}, 0);
    check("dp latency", lat, 55);
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
